// File: rtl/fetch_pc_gen_pkg.sv
// Shared widths, reset address and 2-bit branch history encodings for the
// fetch next-PC generator and its branch history table.
package fetch_pc_gen_pkg;

    localparam int                PC_WIDTH_DEF    = 32;
    localparam int                BTA_WIDTH       = 32;
    localparam int                INDEX_WIDTH_DEF = 3;
    localparam logic [31:0]       RESET_PC_DEF    = 32'h8000_0000;
    localparam int                CNT_WIDTH_DEF   = 16;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    // Saturating step of a 2-bit direction counter.
    function automatic bht_state_e bht_next(input bht_state_e cur, input logic taken);
        bht_state_e nxt;
        nxt = cur;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fetch_pc_gen_bht_table.sv
// Branch history table: 2-bit saturating counters with one combinational
// read port and one synchronous training port.
module bht_table
    import fetch_pc_gen_pkg::*;
#(
    parameter int INDEX_WIDTH = 3,
    parameter int ENTRIES     = 8
) (
    input  logic                   clk_i,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output bht_state_e             rd_state,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic                   wr_taken
);

    bht_state_e table_q [ENTRIES];

    // NOTE: this small table must come out of reset in a known state, so it
    // is built from resettable flops rather than a RAM macro.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= WNT;
            end
        end else if (wr_en) begin
            table_q[wr_index] <= bht_next(table_q[wr_index], wr_taken);
        end
    end

    // NOTE: the read is taken straight from the flops, so a lookup in the
    // same cycle as a write to that entry sees the pre-update value.
    assign rd_state = table_q[rd_index];

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: holds the fetch PC, drives the BTB lookup,
// predicts direction from the BHT and keeps saturating event counters.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter int                  PC_WIDTH    = PC_WIDTH_DEF,
    parameter int                  INDEX_WIDTH = INDEX_WIDTH_DEF,
    parameter int                  BHT_ENTRIES = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = RESET_PC_DEF,
    parameter int                  CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    input  logic                   upd_valid_i,
    input  logic [INDEX_WIDTH-1:0] upd_index_i,
    input  logic                   upd_taken_i,
    input  logic                   btb_hit_i,
    input  logic [PC_WIDTH-1:0]    btb_addr_i,
    output logic [PC_WIDTH-1:0]    pc_o,
    output logic                   fetch_valid_o,
    output logic                   btb_valid_o,
    output logic [INDEX_WIDTH-1:0] btb_index_o,
    output logic [PC_WIDTH-1:0]    btb_tag_o,
    output logic                   pred_taken_o,
    output logic [CNT_WIDTH-1:0]   pred_cnt_o,
    output logic [CNT_WIDTH-1:0]   redirect_cnt_o
);

    logic [PC_WIDTH-1:0]  pc_q;
    logic [PC_WIDTH-1:0]  pc_d;
    logic                 valid_q;
    logic                 fetch_valid;
    bht_state_e           bht_rd;
    logic [CNT_WIDTH-1:0] pred_cnt_q;
    logic [CNT_WIDTH-1:0] redirect_cnt_q;

    // Low address bits of incoming targets are word-alignment don't-cares.
    logic unused_low_bits;
    assign unused_low_bits = ^{redirect_pc_i[1:0], btb_addr_i[1:0]};

    bht_table #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .ENTRIES     (BHT_ENTRIES)
    ) u_bht (
        .clk_i    (clk_i),
        .rst      (rst),
        .rd_index (pc_q[INDEX_WIDTH+1:2]),
        .rd_state (bht_rd),
        .wr_en    (upd_valid_i),
        .wr_index (upd_index_i),
        .wr_taken (upd_taken_i)
    );

    assign fetch_valid    = valid_q & ~stall_i & ~redirect_i;
    assign fetch_valid_o  = fetch_valid;
    assign btb_valid_o    = fetch_valid;
    assign pc_o           = pc_q;
    assign btb_tag_o      = pc_q;
    assign btb_index_o    = pc_q[INDEX_WIDTH+1:2];
    assign pred_taken_o   = fetch_valid & btb_hit_i & (bht_rd inside {WT, ST});
    assign pred_cnt_o     = pred_cnt_q;
    assign redirect_cnt_o = redirect_cnt_q;

    // Redirect outranks stall; a prediction only exists for a live fetch.
    always_comb begin
        pc_d = pc_q + PC_WIDTH'(4);
        if (redirect_i) begin
            pc_d = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (pred_taken_o) begin
            pc_d = {btb_addr_i[PC_WIDTH-1:2], 2'b00};
        end
    end

    // NOTE: every register here uses non-blocking assignment so all state
    // advances together on the edge regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            valid_q        <= 1'b0;
            pred_cnt_q     <= '0;
            redirect_cnt_q <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
            if (pred_taken_o && (pred_cnt_q != '1)) begin
                pred_cnt_q <= pred_cnt_q + CNT_WIDTH'(1);
            end
            if (redirect_i && (redirect_cnt_q != '1)) begin
                redirect_cnt_q <= redirect_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Fetch-stage next-PC generator that sits directly upstream of the branch target buffer.
- Holds the architectural fetch PC and drives the BTB lookup (index, tag, lookup valid).
- Combines the BTB hit/target with an internal 2-bit branch history table (BHT) to predict taken/not-taken, then selects the next PC.
- Accepts stall from decode and mispredict redirect plus BHT training from execute; keeps saturating performance counters.

Parameters:
- PC_WIDTH, 32, width of PC and BTB tag/target.
- INDEX_WIDTH, 3, BTB/BHT index width; index = PC[INDEX_WIDTH+1:2].
- BHT_ENTRIES, 8, number of 2-bit counters; must equal 2**INDEX_WIDTH.
- RESET_PC, 32'h8000_0000, fetch address after reset.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_i  input  1  hold the PC; no new fetch issued.
- redirect_i  input  1  execute-stage mispredict; load redirect_pc_i.
- redirect_pc_i  input  PC_WIDTH  correct target; bits [1:0] ignored.
- upd_valid_i  input  1  BHT training strobe from execute.
- upd_index_i  input  INDEX_WIDTH  BHT entry to train.
- upd_taken_i  input  1  resolved direction.
- btb_hit_i  input  1  BTB hit for current lookup.
- btb_addr_i  input  PC_WIDTH  BTB predicted target.
- pc_o  output  PC_WIDTH  current fetch PC.
- fetch_valid_o  output  1  pc_o is a real fetch this cycle.
- btb_valid_o  output  1  BTB lookup valid, driven to the BTB jmp_vaild input.
- btb_index_o  output  INDEX_WIDTH  pc_o[INDEX_WIDTH+1:2].
- btb_tag_o  output  PC_WIDTH  equals pc_o.
- pred_taken_o  output  1  prediction for the current fetch.
- pred_cnt_o  output  CNT_WIDTH  number of taken predictions issued.
- redirect_cnt_o  output  CNT_WIDTH  number of redirects taken.

Behaviour:
- Reset values (during rst):
  - pc_q <= RESET_PC, valid_q <= 0.
  - All BHT entries <= 2'b01 (weakly not-taken).
  - Both counters <= 0.
  - Outputs during and right after reset: pc_o = RESET_PC, fetch_valid_o = 0, btb_valid_o = 0, pred_taken_o = 0, counters = 0.
- valid_q goes to 1 on the first edge with rst low and stays 1 until the next reset.
- Combinational outputs:
  - fetch_valid_o = valid_q & ~stall_i & ~redirect_i.
  - btb_valid_o = fetch_valid_o.
  - pred_taken_o = fetch_valid_o & btb_hit_i & bht[btb_index_o][1].
- Next-PC priority, evaluated each edge when rst is low:
  1. redirect_i: pc_q <= {redirect_pc_i[PC_WIDTH-1:2], 2'b00}. Wins over stall_i.
  2. stall_i: pc_q holds.
  3. pred_taken_o: pc_q <= {btb_addr_i[PC_WIDTH-1:2], 2'b00}.
  4. Otherwise: pc_q <= pc_q + 4, modulo 2**PC_WIDTH. 0xFFFF_FFFC wraps to 0x0000_0000.
- Latency: a redirect is visible on pc_o the cycle after redirect_i is sampled. No extra bubble beyond the redirect cycle itself.
- pc_q[1:0] is always 00.
- BHT update:
  - When upd_valid_i, the entry at upd_index_i saturates up if upd_taken_i, else down. Range 00..11; 11+taken stays 11, 00+not-taken stays 00.
  - Updates happen independently of stall_i and redirect_i.
  - Same-cycle lookup and update of the same index: the lookup uses the old value (read-before-write).
- Counters:
  - pred_cnt increments on each edge where pred_taken_o = 1.
  - redirect_cnt increments on each edge where redirect_i = 1.
  - Both saturate at all-ones and do not wrap.
- Reset asserted mid-stream overrides redirect, stall and update in the same cycle.
- btb_hit_i is ignored whenever fetch_valid_o = 0.

Decomposition:
- Add to define.v: PC_WIDTH, BTA_WIDTH, BTB index width, RESET_PC, and BHT encodings SNT=00, WNT=01, WT=10, ST=11.
- One sub-module, bht_table:
  - BHT_ENTRIES x 2-bit saturating counters.
  - One combinational read port and one synchronous write port with read-before-write.
  - Synchronous reset to WNT.

Test Plan:
- Reset release: rst high 2 cycles, then low. pc_o = 0x8000_0000 with fetch_valid_o = 0 on the first cycle after release, then fetch_valid_o = 1 and pc_o = 0x8000_0004, 0x8000_0008 on successive cycles.
- Prediction training:
  - Train index 1 taken twice (01 -> 10 -> 11).
  - Fetch pc_o = 0x8000_0004 with btb_hit_i = 1, btb_addr_i = 0x8000_0100 -> pred_taken_o = 1, next pc_o = 0x8000_0100, pred_cnt_o = 1.
  - With an untrained entry (WNT) and a BTB hit -> pred_taken_o = 0, next pc_o = pc+4.
- Stall/redirect priority:
  - stall_i = 1 for 3 cycles -> pc_o constant, fetch_valid_o = 0.
  - stall_i = 1 and redirect_i = 1 with redirect_pc_i = 0x8000_0203 -> next pc_o = 0x8000_0200, redirect_cnt_o = 1.
- BHT saturation and read-before-write:
  - 5 taken updates to index 2 -> entry = 11.
  - A not-taken update in the same cycle as a lookup of index 2 with a BTB hit -> pred_taken_o = 1 that cycle; the entry reads 10 afterwards.
- Wrap-around: redirect to 0xFFFF_FFFC with no hit -> next pc_o = 0x0000_0000.
- Counter saturation: force redirect_i high for 2**CNT_WIDTH + 3 cycles -> redirect_cnt_o stays at all-ones.
- Mid-operation reset: assert rst in the same cycle as redirect_i and upd_valid_i -> pc_o = RESET_PC, all BHT entries = 01, both counters = 0.
